// File: rtl/reg16_wr_arb_pkg.sv
// Shared types and default parameters for the two-requester register write arbiter.
package reg16_wr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DEF_DW         = 16;
    localparam logic [3:0]  DEF_VIEW_ZMASK = 4'b0010;

endpackage

// File: rtl/reg16_wr_arb_if.sv
// Two-requester write-beat bus: valid/last/data/nibble-enables toward the arbiter, ready back.
interface reg16_wr_arb_if #(
    parameter int unsigned DW = reg16_wr_arb_pkg::DEF_DW
);
    logic [1:0]      req_valid;
    logic [1:0]      req_last;
    logic [DW-1:0]   req_data0;
    logic [DW-1:0]   req_data1;
    logic [DW/4-1:0] req_nben0;
    logic [DW/4-1:0] req_nben1;
    logic [1:0]      req_ready;

    modport master (
        output req_valid, req_last, req_data0, req_data1, req_nben0, req_nben1,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_last, req_data0, req_data1, req_nben0, req_nben1,
        output req_ready
    );
endinterface

// File: rtl/reg16_wr_arb_rr_pick2.sv
// Two-way round-robin pick: a lone valid wins, on a tie the requester that is not last_owner wins.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_owner,
    output logic       grant,
    output logic       any
);
    always_comb begin
        any   = |valid;
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_owner;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end
endmodule

// File: rtl/reg16_wr_arb.sv
// Round-robin write arbiter for one shared nibble-enabled register with non-preemptive bursts.
// Optional burst-grant counters are built when REG16_WR_ARB_STATS_EN is defined.
module reg16_wr_arb
    import reg16_wr_arb_pkg::*;
#(
    parameter int unsigned      DW         = DEF_DW,
    parameter logic [DW/4-1:0]  VIEW_ZMASK = DEF_VIEW_ZMASK
) (
    input  logic            clk,
    input  logic            rst,
    reg16_wr_arb_if.slave   bus,
    output logic [DW-1:0]   reg_q,
    output logic [DW-1:0]   reg_view,
    output logic            owner,
    output logic            busy,
    output logic [15:0]     stat_grants0,
    output logic [15:0]     stat_grants1
);
    localparam int unsigned NW = DW / 4;

    state_t          state;
    logic            pick_idx;
    logic            pick_any;
    logic [1:0]      ready;
    logic [1:0]      accept;
    logic            acc_any;
    logic            acc_idx;
    logic            acc_last;
    logic [DW-1:0]   wr_data;
    logic [NW-1:0]   wr_nben;
    logic [DW-1:0]   next_q;

    rr_pick2 u_pick (
        .valid      (bus.req_valid),
        .last_owner (owner),
        .grant      (pick_idx),
        .any        (pick_any)
    );

    // Ready: picked requester in IDLE, locked owner in BUSY, nobody under reset.
    always_comb begin
        ready = 2'b00;
        if (!rst) begin
            if (state == IDLE) begin
                ready[pick_idx] = pick_any;
            end else begin
                ready[owner] = 1'b1;
            end
        end
    end

    assign bus.req_ready = ready;
    assign accept        = bus.req_valid & ready;
    assign acc_any       = |accept;
    assign acc_idx       = accept[1];
    assign acc_last      = bus.req_last[acc_idx];
    assign wr_data       = acc_idx ? bus.req_data1 : bus.req_data0;
    assign wr_nben       = acc_idx ? bus.req_nben1 : bus.req_nben0;
    assign busy          = (state == BUSY);

    for (genvar n = 0; n < NW; n++) begin : g_nib
        assign next_q[n*4 +: 4]   = (acc_any && wr_nben[n]) ? wr_data[n*4 +: 4] : reg_q[n*4 +: 4];
        assign reg_view[n*4 +: 4] = VIEW_ZMASK[n] ? 4'h0 : reg_q[n*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            reg_q <= '0;
            owner <= 1'b1;
        end else if (acc_any) begin
            reg_q <= next_q;
            case (state)
                IDLE: begin
                    owner <= acc_idx;
                    state <= acc_last ? IDLE : BUSY;
                end
                BUSY: begin
                    if (acc_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REG16_WR_ARB_STATS_EN
    // Count first beats only; continuation beats in BUSY are not new grants.
    logic first_grant;
    assign first_grant = acc_any && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants0 <= '0;
            stat_grants1 <= '0;
        end else if (first_grant) begin
            if (!acc_idx && stat_grants0 != 16'hFFFF) begin
                stat_grants0 <= stat_grants0 + 16'd1;
            end
            if (acc_idx && stat_grants1 != 16'hFFFF) begin
                stat_grants1 <= stat_grants1 + 16'd1;
            end
        end
    end
`else
    assign stat_grants0 = '0;
    assign stat_grants1 = '0;
`endif

endmodule
